// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: control-bundle bit positions and special register indices.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipeline_pkg;

  localparam int CTRL_W = 13;

  // Bit positions inside the decoded control bundle
  // {CB_instr, ALUSrc, MemtoReg, Branch, MemRead, MemWrite, RegWrite,
  //  Uncondbranch, Branchlink, Branchreg, not_zero, ALUOp[1:0]}
  localparam int CTRL_CB_INSTR     = 12;
  localparam int CTRL_ALUSRC       = 11;
  localparam int CTRL_MEMTOREG     = 10;
  localparam int CTRL_BRANCH       = 9;
  localparam int CTRL_MEMREAD      = 8;
  localparam int CTRL_MEMWRITE     = 7;
  localparam int CTRL_REGWRITE     = 6;
  localparam int CTRL_UNCONDBRANCH = 5;
  localparam int CTRL_BRANCHLINK   = 4;
  localparam int CTRL_BRANCHREG    = 3;
  localparam int CTRL_NOT_ZERO     = 2;
  localparam int CTRL_ALUOP_LSB    = 0;

  // XZR: reads as zero, writes are discarded, so it never creates a dependency
  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: load in EX whose destination is read by the instruction in ID.
// Latency: purely combinational.
// Backpressure: none; the result feeds the stall/bubble logic of id_ex_stage.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  output logic             lu
);

  // Source 2 is always compared, even for immediate forms (conservative on purpose)
  always_comb begin
    lu = ex_valid & ex_memread & id_valid & (ex_rd != REG_W'(XZR)) &
         ((ex_rd == id_rn) | (ex_rd == id_rm));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush (optional stall counter: ID_EX_STALL_CNT_EN).
// Latency: one cycle from id_* to ex_*; pc_write/ifid_write/bubble are combinational.
// Backpressure: hold freezes the stage; a load-use hazard drops pc_write/ifid_write for exactly one cycle.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [10:0]       id_opcode,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  input  logic              hold,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [10:0]       ex_opcode,
  output logic [REG_W-1:0]  ex_rn,
  output logic [REG_W-1:0]  ex_rm,
  output logic [REG_W-1:0]  ex_rd,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              bubble
);

  logic lu;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl[CTRL_MEMREAD]),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .lu         (lu)
  );

  // Flush overrides a load-use stall (upstream flush already squashes IF/ID); hold overrides both
  always_comb begin
    pc_write   = ~(lu & ~flush) & ~hold;
    ifid_write = pc_write;
    bubble     = lu & ~flush & ~hold;
  end

  // Pipeline registers: flush > hold > load-use bubble > normal load; data rides along whenever not held
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_pc     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_opcode <= '0;
      ex_rn     <= '0;
      ex_rm     <= '0;
      ex_rd     <= '0;
    end else if (flush || !hold) begin
      ex_pc     <= id_pc;
      ex_rd1    <= id_rd1;
      ex_rd2    <= id_rd2;
      ex_imm    <= id_imm;
      ex_opcode <= id_opcode;
      ex_rn     <= id_rn;
      ex_rm     <= id_rm;
      ex_rd     <= id_rd;
      if (flush || lu) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : '0;
      end
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Saturating count of inserted load-use bubbles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (bubble && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int MR = 8;  // MemRead bit in the control bundle
  localparam logic [12:0] C_LDUR = 13'h0D40;  // ALUSrc, MemtoReg, MemRead, RegWrite
  localparam logic [12:0] C_ADD  = 13'h0042;  // RegWrite, ALUOp=10

  typedef struct packed {
    logic        valid;
    logic [12:0] ctrl;
    logic [63:0] pc, rd1, rd2, imm;
    logic [10:0] opcode;
    logic [4:0]  rn, rm, rd;
  } ex_t;

  typedef struct packed {
    logic full;  // 0: only valid/ctrl are defined (bubble or flush)
    ex_t  v;
  } sb_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] id_ctrl = '0;
  logic        id_valid = 1'b0;
  logic [63:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [10:0] id_opcode = '0;
  logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
  logic        flush = 1'b0, hold = 1'b0;
  logic [12:0] ex_ctrl;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [10:0] ex_opcode;
  logic [4:0]  ex_rn, ex_rm, ex_rd;
  logic        pc_write, ifid_write, bubble;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int  n_cmp = 0;
  int  n_err = 0;
  sb_t model;
  sb_t sb_q[$];

  always #5 clock = ~clock;

  id_ex_stage #(.DATA_W(64), .REG_W(5)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
`ifdef ID_EX_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .id_ctrl    (id_ctrl),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_rd1     (id_rd1),
    .id_rd2     (id_rd2),
    .id_imm     (id_imm),
    .id_opcode  (id_opcode),
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_rd      (id_rd),
    .flush      (flush),
    .hold       (hold),
    .ex_ctrl    (ex_ctrl),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_rd1     (ex_rd1),
    .ex_rd2     (ex_rd2),
    .ex_imm     (ex_imm),
    .ex_opcode  (ex_opcode),
    .ex_rn      (ex_rn),
    .ex_rm      (ex_rm),
    .ex_rd      (ex_rd),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .bubble     (bubble)
  );

  function automatic ex_t get_ex();
    return '{ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_opcode, ex_rn, ex_rm, ex_rd};
  endfunction

  // What a normal (no hazard, no flush, no hold) edge should load
  function automatic ex_t id_as_ex();
    return '{id_valid, (id_valid ? id_ctrl : 13'h0), id_pc, id_rd1, id_rd2, id_imm,
             id_opcode, id_rn, id_rm, id_rd};
  endfunction

  function automatic logic model_lu();
    return model.v.valid & model.v.ctrl[MR] & id_valid & (model.v.rd != 5'd31) &
           ((model.v.rd == id_rn) | (model.v.rd == id_rm));
  endfunction

  task automatic set_id(input logic v, input logic [12:0] c, input logic [63:0] pc,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd);
    id_valid  = v;
    id_ctrl   = c;
    id_pc     = pc;
    id_rd1    = {$urandom, $urandom};
    id_rd2    = {$urandom, $urandom};
    id_imm    = {$urandom, $urandom};
    id_opcode = 11'($urandom);
    id_rn     = rn;
    id_rm     = rm;
    id_rd     = rd;
  endtask

  task automatic push_exp(input logic full, input ex_t v);
    sb_t e;
    e.full = full;
    e.v    = v;
    sb_q.push_back(e);
    model = e;
  endtask

  task automatic push_bubble();
    ex_t z;
    z = '0;
    push_exp(1'b0, z);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    ex_t g;
    #12;
    g = get_ex();
    n_cmp++;
    if (g !== '0) begin
      n_err++;
      $display("FAIL reset_ex: got %h required 0", g);
    end
    n_cmp++;
    if ({bubble, pc_write, ifid_write} !== 3'b011) begin
      n_err++;
      $display("FAIL reset_ctl: got %b required 011", {bubble, pc_write, ifid_write});
    end
    reset_n = 1'b1;
    model = '{1'b1, '0};
    push_exp(1'b1, id_as_ex());
    tick();
    begin
      sb_t e = sb_q.pop_front();
      g = get_ex(); n_cmp++;
      if (g !== e.v) begin n_err++; $display("FAIL reset_first_load: got %h required %h", g, e.v); end
    end
  endtask

  // LDUR in EX followed by a consumer on rn or rm: one bubble, then the consumer loads
  task automatic test_load_use();
    logic [4:0] tbl_rd[2] = '{5'd1, 5'd5};
    logic [4:0] tbl_rn[2] = '{5'd1, 5'd7};
    logic [4:0] tbl_rm[2] = '{5'd3, 5'd5};
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) begin
        logic [2:0] exp_ctl;
        sb_t e;
        ex_t g;
        if (c == 0) set_id(1'b1, C_LDUR, 64'h100 + 64'(i * 16), 5'd9, 5'd0, tbl_rd[i]);
        if (c == 1) set_id(1'b1, C_ADD, 64'h104 + 64'(i * 16), tbl_rn[i], tbl_rm[i], 5'd2);
        #1;
        exp_ctl = (c == 1) ? 3'b100 : 3'b011;
        n_cmp++;
        if ({bubble, pc_write, ifid_write} !== exp_ctl) begin
          n_err++;
          $display("FAIL load_use_ctl[%0d.%0d]: got %b required %b", i, c, {bubble, pc_write, ifid_write}, exp_ctl);
        end
        if (c == 1) push_bubble(); else push_exp(1'b1, id_as_ex());
        tick();
        e = sb_q.pop_front(); g = get_ex(); n_cmp++;
        if (e.full ? (g !== e.v) : ({g.valid, g.ctrl} !== {e.v.valid, e.v.ctrl})) begin
          n_err++;
          $display("FAIL load_use_ex[%0d.%0d]: got %h required %h", i, c, g, e.v);
        end
      end
    end
  endtask

  // Cases that look close to a hazard but must not stall
  task automatic test_no_hazard();
    logic [12:0] t_ctrl[4] = '{C_LDUR, C_ADD, C_LDUR, C_LDUR};
    logic [4:0]  t_rd[4]   = '{5'd31, 5'd1, 5'd1, 5'd1};
    logic        t_vld[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0]  t_rn[4]   = '{5'd31, 5'd1, 5'd1, 5'd2};
    logic [4:0]  t_rm[4]   = '{5'd31, 5'd1, 5'd1, 5'd3};
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 2; c++) begin
        sb_t e;
        ex_t g;
        if (c == 0) set_id(1'b1, t_ctrl[i], 64'h200 + 64'(i * 8), 5'd4, 5'd6, t_rd[i]);
        else        set_id(t_vld[i], C_ADD, 64'h204 + 64'(i * 8), t_rn[i], t_rm[i], 5'd8);
        #1;
        n_cmp++;
        if ({bubble, pc_write, ifid_write} !== 3'b011) begin
          n_err++;
          $display("FAIL no_hazard_ctl[%0d.%0d]: got %b required 011", i, c, {bubble, pc_write, ifid_write});
        end
        push_exp(1'b1, id_as_ex());
        tick();
        e = sb_q.pop_front(); g = get_ex(); n_cmp++;
        if (g !== e.v) begin n_err++; $display("FAIL no_hazard_ex[%0d.%0d]: got %h required %h", i, c, g, e.v); end
      end
    end
  endtask

  task automatic test_flush_lu();
    sb_t e;
    ex_t g;
    set_id(1'b1, C_LDUR, 64'h300, 5'd4, 5'd0, 5'd1);
    push_exp(1'b1, id_as_ex());
    tick();
    e = sb_q.pop_front(); g = get_ex(); n_cmp++;
    if (g !== e.v) begin n_err++; $display("FAIL flush_setup_ex: got %h required %h", g, e.v); end
    set_id(1'b1, C_ADD, 64'h304, 5'd1, 5'd3, 5'd2);
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({bubble, pc_write, ifid_write} !== 3'b011) begin
      n_err++;
      $display("FAIL flush_lu_ctl: got %b required 011", {bubble, pc_write, ifid_write});
    end
    push_bubble();
    tick();
    flush = 1'b0;
    e = sb_q.pop_front(); g = get_ex(); n_cmp++;
    if ({g.valid, g.ctrl} !== {e.v.valid, e.v.ctrl}) begin
      n_err++;
      $display("FAIL flush_lu_ex: got valid=%b ctrl=%h required valid=0 ctrl=0", g.valid, g.ctrl);
    end
  endtask

  // Hold for 3 cycles at pc 0x40, release loads 0x44; then hold masking a load-use; then hold+flush
  task automatic test_hold();
    for (int c = 0; c < 11; c++) begin
      logic [2:0] exp_ctl;
      sb_t e;
      ex_t g;
      hold = 1'b0;
      flush = 1'b0;
      case (c)
        0: set_id(1'b1, C_ADD, 64'h40, 5'd4, 5'd5, 5'd6);
        1: begin set_id(1'b1, C_ADD, 64'h44, 5'd4, 5'd5, 5'd7); hold = 1'b1; end
        2, 3: hold = 1'b1;
        5: set_id(1'b1, C_LDUR, 64'h48, 5'd4, 5'd0, 5'd1);
        6: begin set_id(1'b1, C_ADD, 64'h4C, 5'd1, 5'd3, 5'd2); hold = 1'b1; end
        9: begin set_id(1'b1, C_ADD, 64'h50, 5'd4, 5'd5, 5'd6); hold = 1'b1; flush = 1'b1; end
        default: ;
      endcase
      #1;
      exp_ctl = hold ? 3'b000 : (model_lu() ? 3'b100 : 3'b011);
      if (flush) exp_ctl = 3'b000;
      n_cmp++;
      if ({bubble, pc_write, ifid_write} !== exp_ctl) begin
        n_err++;
        $display("FAIL hold_ctl[%0d]: got %b required %b", c, {bubble, pc_write, ifid_write}, exp_ctl);
      end
      if (flush) push_bubble();
      else if (hold) push_exp(model.full, model.v);
      else if (model_lu()) push_bubble();
      else push_exp(1'b1, id_as_ex());
      tick();
      e = sb_q.pop_front(); g = get_ex(); n_cmp++;
      if (e.full ? (g !== e.v) : ({g.valid, g.ctrl} !== {e.v.valid, e.v.ctrl})) begin
        n_err++;
        $display("FAIL hold_ex[%0d]: got %h required %h", c, g, e.v);
      end
      if (c == 3) begin
        n_cmp++;
        if (ex_pc !== 64'h40) begin n_err++; $display("FAIL hold_pc: got %h required 40", ex_pc); end
      end
    end
    hold = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    sb_t e;
    ex_t g;
    set_id(1'b1, C_LDUR, 64'h600, 5'd2, 5'd3, 5'd4);
    push_exp(1'b1, id_as_ex());
    tick();
    e = sb_q.pop_front(); g = get_ex(); n_cmp++;
    if (g !== e.v) begin n_err++; $display("FAIL areset_setup_ex: got %h required %h", g, e.v); end
    #2;
    reset_n = 1'b0;
    #1;
    g = get_ex(); n_cmp++;
    if (g !== '0) begin n_err++; $display("FAIL areset_ex: got %h required 0", g); end
    reset_n = 1'b1;
    model = '{1'b1, '0};
    set_id(1'b1, C_ADD, 64'h604, 5'd4, 5'd3, 5'd5);
    push_exp(1'b1, id_as_ex());
    tick();
    e = sb_q.pop_front(); g = get_ex(); n_cmp++;
    if (g !== e.v) begin n_err++; $display("FAIL areset_reload_ex: got %h required %h", g, e.v); end
  endtask

  // Random back-to-back traffic with flush/hold; a stalled instruction is re-presented
  task automatic test_back_to_back();
    logic [4:0] regs[4] = '{5'd1, 5'd2, 5'd3, 5'd31};
    logic       re_present = 1'b0;
    for (int c = 0; c < 80; c++) begin
      logic lu, eb, ep;
      sb_t  e;
      ex_t  g;
      if (!re_present) begin
        logic [12:0] cc;
        cc = 13'($urandom);
        cc[MR] = $urandom_range(0, 1) == 1;
        set_id($urandom_range(0, 7) != 0, cc, {$urandom, $urandom},
               regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)]);
      end
      flush = $urandom_range(0, 7) == 0;
      hold  = $urandom_range(0, 7) == 0;
      #1;
      lu = model_lu();
      eb = lu & ~flush & ~hold;
      ep = ~(lu & ~flush) & ~hold;
      n_cmp++;
      if ({bubble, pc_write, ifid_write} !== {eb, ep, ep}) begin
        n_err++;
        $display("FAIL b2b_ctl[%0d]: got %b required %b", c, {bubble, pc_write, ifid_write}, {eb, ep, ep});
      end
      if (flush || (!hold && lu)) push_bubble();
      else if (hold) push_exp(model.full, model.v);
      else push_exp(1'b1, id_as_ex());
      re_present = ~ep;
      tick();
      e = sb_q.pop_front(); g = get_ex(); n_cmp++;
      if (e.full ? (g !== e.v) : ({g.valid, g.ctrl} !== {e.v.valid, e.v.ctrl})) begin
        n_err++;
        $display("FAIL b2b_ex[%0d]: got %h required %h", c, g, e.v);
      end
    end
    flush = 1'b0;
    hold = 1'b0;
  endtask

`ifdef ID_EX_STALL_CNT_EN
  task automatic test_stall_cnt();
    #2;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, C_LDUR, 64'h700, 5'd4, 5'd0, 5'd1);
      tick();
      set_id(1'b1, C_ADD, 64'h704, 5'd1, 5'd3, 5'd2);
      tick();
      tick();
    end
    n_cmp++;
    if (stall_cnt !== 32'd5) begin n_err++; $display("FAIL stall_cnt: got %0d required 5", stall_cnt); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL stall_cnt_reset: got %0d required 0", stall_cnt); end
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush_lu();
    test_hold();
    test_async_reset();
    test_back_to_back();
`ifdef ID_EX_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the pipelined ARMv8 (LEGv8) core. It sits directly downstream of the instruction-decode control unit. It latches the decoded control bundle and the register/immediate operands into the EX stage. It also detects load-use hazards against the instruction currently in EX and inserts one bubble, and it squashes the stage on a branch-resolution flush.

## Interface
Parameters:
- `DATA_W`, 64: operand and PC width.
- `REG_W`, 5: register index width.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: **asynchronous, active-low** reset.
- `id_ctrl` input 13: decoded control bundle `{CB_instr, ALUSrc, MemtoReg, Branch, MemRead, MemWrite, RegWrite, Uncondbranch, Branchlink, Branchreg, not_zero, ALUOp[1:0]}`.
- `id_valid` input 1: the IF/ID register holds a real instruction.
- `id_pc`, `id_rd1`, `id_rd2`, `id_imm` input DATA_W: PC, register-file read data, sign-extended immediate.
- `id_opcode` input 11: instruction[31:21], forwarded to the ALU control.
- `id_rn`, `id_rm`, `id_rd` input REG_W: source 1, source 2 (post-Reg2Loc mux), destination.
- `flush` input 1: branch taken in a later stage; squash ID/EX.
- `hold` input 1: global stall (e.g. memory wait); freeze the stage.
- `ex_ctrl`, `ex_valid`, `ex_pc`, `ex_rd1`, `ex_rd2`, `ex_imm`, `ex_opcode`, `ex_rn`, `ex_rm`, `ex_rd` output (matching widths): registered EX-stage copies.
- `pc_write` output 1: 0 freezes the PC.
- `ifid_write` output 1: 0 freezes the IF/ID register.
- `bubble` output 1: a load-use bubble is being inserted this cycle.

## Operation
Load-use detect (combinational):
- `lu = ex_valid & ex_ctrl.MemRead & id_valid & (ex_rd != 31) & ((ex_rd == id_rn) | (ex_rd == id_rm))`.
- Index 31 (XZR) never matches.
- Source 2 is compared unconditionally, even for immediate forms. This is deliberately conservative.

Per-edge priority:
1. `reset_n` low: all registered outputs go to 0.
2. `flush`: `ex_valid` and `ex_ctrl` are cleared to 0. Data fields are don't-care (implementation loads them).
3. `hold`: all registers keep their value. `bubble` = 0.
4. `lu`: bubble. `ex_valid` and `ex_ctrl` are cleared. `pc_write` and `ifid_write` are 0, so the ID instruction is re-presented next cycle.
5. Otherwise: load all `id_*` fields. `ex_ctrl` = `id_valid ? id_ctrl : 0`.

Output rules:
- `pc_write = ifid_write = ~(lu & ~flush) & ~hold`.
- `bubble = lu & ~flush & ~hold`.
- After one bubble, EX holds the bubble, so `lu` deasserts by construction. A load-use stall therefore lasts exactly one cycle.
- Flush and load-use in the same cycle: flush wins. PC and IF/ID are not frozen, because the upstream flush handles IF/ID.

## Timing
- One-cycle latency: `id_*` at edge N appears on `ex_*` after edge N.
- `pc_write`, `ifid_write` and `bubble` are combinational from current `ex_*` and `id_*`. There is no internal state beyond the pipeline registers (plus the counter below).
- Reset mid-operation clears the stage immediately, without waiting for a clock edge. The first edge after deassertion loads normally.
- `hold` and `flush` together: flush wins and clears the stage.

## Configuration
- `ID_EX_STALL_CNT_EN` defined: adds output `stall_cnt` (32 bits).
  - Increments once on every edge where `bubble` = 1.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset.
- `ID_EX_STALL_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `pipeline_pkg` holds:
  - the control-bundle bit positions and the width constant `CTRL_W = 13`;
  - the `XZR = 5'd31` constant.
- Sub-module `hazard_detect`: purely combinational. It computes `lu` from `ex_valid`, `ex_memread`, `ex_rd`, `id_valid`, `id_rn` and `id_rm`.
- The top level holds the registers and the priority logic.

## Test plan
- LDUR X1 in EX (MemRead = 1, `ex_rd` = 1), ADD X2,X1,X3 in ID (`id_rn` = 1): expect `bubble` = 1, `pc_write` = 0, `ex_ctrl` = 0 after the edge, and the ADD loaded on the following edge with `bubble` = 0.
- LDUR X31 in EX, ID reads `id_rn` = 31: expect no stall (`bubble` = 0).
- Load-use condition with `flush` = 1 in the same cycle: expect `ex_valid` = 0, `pc_write` = 1, `bubble` = 0.
- `hold` = 1 for 3 cycles with `ex_pc` = 0x40: expect `ex_pc` to stay 0x40 and `pc_write` = 0. After release, `id_pc` = 0x44 is loaded.
- Assert `reset_n` low mid-stream with `ex_ctrl` nonzero: expect all `ex_*` = 0 before the next clock edge.
- With `ID_EX_STALL_CNT_EN`: 5 load-use stalls, then reset. Expect `stall_cnt` = 5, then 0 after reset.
